// File: rtl/reaction_time_keeper_pkg.sv
// Shared constants for the reaction timer and the display mux.
// FSM encoding, BCD limits and the best-time reset value live here.
package reaction_time_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0]  BCD_MAX     = 4'd9;
    localparam logic [15:0] BCD_ALL_MAX = 16'h9999;
    localparam logic [15:0] HS_INIT_DEF = 16'h9999;

    // Most significant differing digit decides the order.
    function automatic logic bcd_lt(input logic [15:0] a,
                                    input logic [15:0] b);
        logic lt;
        logic decided;
        lt      = 1'b0;
        decided = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                lt      = a[4*i +: 4] < b[4*i +: 4];
                decided = 1'b1;
            end
        end
        return lt;
    endfunction

endpackage

// File: rtl/reaction_time_keeper_bcd_digit_counter.sv
// One decimal digit of the reaction count.
// Wraps 9->0 with carry out; sat freezes the digit.
module bcd_digit_counter
    import reaction_time_keeper_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       sat,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (inc && !sat) begin
            digit_d = (digit_q >= BCD_MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc && (digit_q == BCD_MAX);

endmodule

// File: rtl/reaction_time_keeper.sv
// Reaction timer: 4-digit BCD tick counter with a best-time register.
// Feeds current and best digits to the 7-segment display mux.
module reaction_time_keeper
    import reaction_time_keeper_pkg::*;
#(
    parameter logic [15:0] HS_INIT  = HS_INIT_DEF,
    parameter bit          SATURATE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear_hs,
    output logic [3:0] BCD3,
    output logic [3:0] BCD2,
    output logic [3:0] BCD1,
    output logic [3:0] BCD0,
    output logic [3:0] HS3,
    output logic [3:0] HS2,
    output logic [3:0] HS1,
    output logic [3:0] HS0,
    output logic       running,
    output logic       new_record,
    output logic       ovf
);

    state_e      state_q, state_d;
    logic [15:0] count;
    logic [15:0] hs_q, hs_d;
    logic        ovf_q, ovf_d;
    logic        running_q;
    logic        nrec_q;
    logic        clr, inc0, rec, sat;
    logic [3:0]  inc;
    logic [3:0]  carry;

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        inc0    = 1'b0;
        rec     = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DONE;
                    rec     = !ovf_q && bcd_lt(count, hs_q);
                end else if (start) begin
                    clr = 1'b1;
                end else begin
                    inc0 = tick;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clr     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Whole counter freezes at 9999 when saturating; otherwise it wraps.
    assign sat = SATURATE && (count == BCD_ALL_MAX);

    // carry[3] fires exactly on a tick taken at 9999.
    always_comb begin
        ovf_d = clr ? 1'b0 : (ovf_q || carry[3]);
        hs_d  = hs_q;
        if (rec) begin
            hs_d = count;
        end else if (clear_hs) begin
            hs_d = HS_INIT;
        end
    end

    assign inc = {carry[2:0], inc0};

    for (genvar g = 0; g < 4; g++) begin : g_dig
        bcd_digit_counter u_dig (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .inc   (inc[g]),
            .sat   (sat),
            .digit (count[4*g +: 4]),
            .carry (carry[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hs_q      <= HS_INIT;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
            nrec_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hs_q      <= hs_d;
            ovf_q     <= ovf_d;
            running_q <= (state_d == ST_RUN);
            nrec_q    <= rec;
        end
    end

    assign {BCD3, BCD2, BCD1, BCD0} = count;
    assign {HS3, HS2, HS1, HS0}     = hs_q;
    assign running    = running_q;
    assign new_record = nrec_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_reaction_time_keeper.sv
// Directed bench for reaction_time_keeper.
// Two instances share stimulus: saturating and wrapping counters.
module tb_reaction_time_keeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic clear_hs = 1'b0;

    logic [3:0] b3, b2, b1, b0, h3, h2, h1, h0;
    logic       running, nrec, ovf;
    logic [3:0] wb3, wb2, wb1, wb0, wh3, wh2, wh1, wh0;
    logic       wrunning, wnrec, wovf;

    logic [15:0] bcd, hs, wbcd, whs;
    assign bcd  = {b3, b2, b1, b0};
    assign hs   = {h3, h2, h1, h0};
    assign wbcd = {wb3, wb2, wb1, wb0};
    assign whs  = {wh3, wh2, wh1, wh0};

    int   checks = 0;
    int   errors = 0;
    logic digit_bad = 1'b0;

    always #5 clk = ~clk;

    reaction_time_keeper #(.HS_INIT(16'h9999), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .clear_hs(clear_hs),
        .BCD3(b3), .BCD2(b2), .BCD1(b1), .BCD0(b0),
        .HS3(h3), .HS2(h2), .HS1(h1), .HS0(h0),
        .running(running), .new_record(nrec), .ovf(ovf)
    );

    reaction_time_keeper #(.HS_INIT(16'h9999), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .clear_hs(clear_hs),
        .BCD3(wb3), .BCD2(wb2), .BCD1(wb1), .BCD0(wb0),
        .HS3(wh3), .HS2(wh2), .HS1(wh1), .HS0(wh0),
        .running(wrunning), .new_record(wnrec), .ovf(wovf)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read one falling edge later.
    task automatic cyc(input logic t, input logic s, input logic p,
                       input logic c);
        tick = t;
        start = s;
        stop = p;
        clear_hs = c;
        @(negedge clk);
        tick = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        clear_hs = 1'b0;
        if (b3 > 4'd9 || b2 > 4'd9 || b1 > 4'd9 || b0 > 4'd9 ||
            wb3 > 4'd9 || wb2 > 4'd9 || wb1 > 4'd9 || wb0 > 4'd9)
            digit_bad = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_hs", hs, 16'h9999);
        chk("rst_running", {15'd0, running}, 16'd0);
        chk("rst_nrec", {15'd0, nrec}, 16'd0);
        chk("rst_ovf", {15'd0, ovf}, 16'd0);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t1_running", {15'd0, running}, 16'd1);
        ticks(37);
        chk("t1_count", bcd, 16'h0037);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_bcd", bcd, 16'h0037);
        chk("t1_hs", hs, 16'h0037);
        chk("t1_nrec", {15'd0, nrec}, 16'd1);
        chk("t1_stopped", {15'd0, running}, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_nrec_1cyc", {15'd0, nrec}, 16'd0);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_clr", bcd, 16'h0000);
        ticks(120);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_bcd", bcd, 16'h0120);
        chk("t2_hs", hs, 16'h0037);
        chk("t2_nrec", {15'd0, nrec}, 16'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(37);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_eq_bcd", bcd, 16'h0037);
        chk("t2_eq_hs", hs, 16'h0037);
        chk("t2_eq_nrec", {15'd0, nrec}, 16'd0);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(999);
        chk("t3_999", bcd, 16'h0999);
        ticks(1);
        chk("t3_1000", bcd, 16'h1000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_hs", hs, 16'h0037);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(9999);
        chk("t4_9999", bcd, 16'h9999);
        chk("t4_9999_ovf", {15'd0, ovf}, 16'd0);
        ticks(1);
        chk("t4_sat_bcd", bcd, 16'h9999);
        chk("t4_sat_ovf", {15'd0, ovf}, 16'd1);
        chk("t4_wrap_bcd", wbcd, 16'h0000);
        chk("t4_wrap_ovf", {15'd0, wovf}, 16'd1);
        ticks(3);
        chk("t4_sat_hold", bcd, 16'h9999);
        chk("t4_wrap_after", wbcd, 16'h0003);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_sat_hs", hs, 16'h0037);
        chk("t4_wrap_hs", whs, 16'h0037);
        chk("t4_sat_nrec", {15'd0, nrec}, 16'd0);
        chk("t4_wrap_nrec", {15'd0, wnrec}, 16'd0);
        chk("t4_wrap_running", {15'd0, wrunning}, 16'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_ovf_clr", {15'd0, ovf}, 16'd0);
        chk("t4_wovf_clr", {15'd0, wovf}, 16'd0);

        ticks(41);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_tickstop_bcd", bcd, 16'h0041);
        chk("t5_tickstop_run", {15'd0, running}, 16'd0);
        chk("t5_tickstop_hs", hs, 16'h0037);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_run_ss_run", {15'd0, running}, 16'd0);
        chk("t5_run_ss_bcd", bcd, 16'h0005);
        chk("t5_run_ss_hs", hs, 16'h0005);
        chk("t5_run_ss_nrec", {15'd0, nrec}, 16'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_done_ss_run", {15'd0, running}, 16'd1);
        chk("t5_done_ss_bcd", bcd, 16'h0000);
        ticks(3);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5_clr_stop_hs", hs, 16'h0003);
        chk("t5_clr_stop_nrec", {15'd0, nrec}, 16'd1);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(500);
        chk("t6_500", bcd, 16'h0500);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_run", {15'd0, running}, 16'd0);
        chk("t6_rst_bcd", bcd, 16'h0000);
        chk("t6_rst_hs", hs, 16'h9999);
        chk("t6_rst_ovf", {15'd0, ovf}, 16'd0);
        ticks(2);
        chk("t6_idle_no_count", bcd, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(12);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_rec_hs", hs, 16'h0012);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_clrhs_hs", hs, 16'h9999);
        chk("t6_clrhs_bcd", bcd, 16'h0012);
        chk("t6_clrhs_run", {15'd0, running}, 16'd0);

        chk("digits_le_9", {15'd0, digit_bad}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
